// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame capture, make/break/E0 decoder.
// Optional KEY_REPEAT_FILTER_EN suppresses newKeyStrobe on typematic repeats of the held key.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk100MHz,
    input  logic       rst_n,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] keycode,
    output logic       newKeyStrobe,
    output logic       extended,
    output logic       releasePulse,
    output logic       frameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  clk_f;
    logic                  fall_edge;
    logic [10:0]           frame;
    logic [3:0]            bit_cnt;
    logic                  frame_done;
    logic [TW-1:0]         to_cnt;
    logic                  to_hit;
    logic                  frame_ok;
    logic                  byte_vld;
    logic [7:0]            rx_byte;
    logic [1:0]            state, next_state;
    logic                  do_make, do_break, ext_flag, make_take, is_repeat;

    // Idle bus is high, so sync flops and filter come out of reset at 1.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2Data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            filt_sr <= '1;
            clk_f   <= 1'b1;
        end else begin
            filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (filt_sr == '0)
                clk_f <= 1'b0;
            else if (&filt_sr)
                clk_f <= 1'b1;
        end
    end

    assign fall_edge = clk_f && (filt_sr == '0);
    assign to_hit    = (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fall_edge) begin
                frame <= {dat_s2, frame[10:1]};
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (to_hit) begin
                bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (fall_edge || bit_cnt == 4'd0)
            to_cnt <= '0;
        else if (!to_hit)
            to_cnt <= to_cnt + TW'(1);
    end

    // Start low, stop high, odd parity over data plus parity bit.
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
    assign byte_vld = frame_done & frame_ok;
    assign rx_byte  = frame[8:1];

    always_comb begin
        next_state = state;
        do_make    = 1'b0;
        do_break   = 1'b0;
        ext_flag   = 1'b0;
        if (byte_vld) begin
            case (state)
                IDLE: begin
                    if (rx_byte == 8'hE0)      next_state = EXT;
                    else if (rx_byte == 8'hF0) next_state = BRK;
                    else                       do_make = 1'b1;
                end
                EXT: begin
                    if (rx_byte == 8'hF0)      next_state = EXT_BRK;
                    else if (rx_byte == 8'hE0) next_state = EXT;
                    else begin
                        do_make    = 1'b1;
                        ext_flag   = 1'b1;
                        next_state = IDLE;
                    end
                end
                BRK: begin
                    next_state = IDLE;
                    do_break   = (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
                end
                default: begin
                    next_state = IDLE;
                    do_break   = (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
                    ext_flag   = 1'b1;
                end
            endcase
        end else if (frame_done) begin
            next_state = IDLE;
        end
    end

    assign is_repeat = (rx_byte == keycode) && (ext_flag == extended) && (keycode != 8'h00);

`ifdef KEY_REPEAT_FILTER_EN
    assign make_take = do_make & ~is_repeat;
`else
    assign make_take = do_make;
`endif

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            keycode      <= 8'h00;
            extended     <= 1'b0;
            newKeyStrobe <= 1'b0;
            releasePulse <= 1'b0;
            frameError   <= 1'b0;
        end else begin
            state        <= next_state;
            newKeyStrobe <= 1'b0;
            releasePulse <= 1'b0;
            frameError   <= to_hit | (frame_done & ~frame_ok);
            if (make_take) begin
                keycode      <= rx_byte;
                extended     <= ext_flag;
                newKeyStrobe <= 1'b1;
            end else if (do_break && rx_byte == keycode && ext_flag == extended) begin
                keycode      <= 8'h00;
                extended     <= 1'b0;
                releasePulse <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboarded bench for ps2_keyboard_rx: expected output events queued at stimulus, matched on DUT pulses.
module tb_ps2_keyboard_rx;

    localparam int HALF = 20;
    localparam int TO   = 2000;
    localparam logic [1:0] K_MAKE = 2'd1;
    localparam logic [1:0] K_REL  = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    logic       clk100MHz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       PS2Clk    = 1'b1;
    logic       PS2Data   = 1'b1;
    logic [7:0] keycode;
    logic       newKeyStrobe, extended, releasePulse, frameError;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int strobe_lat = 0;
    int n_strobes = 0;
    logic [31:0] sb[$];

    ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk100MHz    (clk100MHz),
        .rst_n        (rst_n),
        .PS2Clk       (PS2Clk),
        .PS2Data      (PS2Data),
        .keycode      (keycode),
        .newKeyStrobe (newKeyStrobe),
        .extended     (extended),
        .releasePulse (releasePulse),
        .frameError   (frameError)
    );

    always #5 clk100MHz = ~clk100MHz;
    always @(posedge clk100MHz) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [1:0] kind, input logic ext, input logic [7:0] kc);
        return {21'd0, kind, ext, kc};
    endfunction

    task automatic match(input logic [31:0] obs);
        if (sb.size() == 0)
            check("sb_unexpected", obs, 32'h0);
        else
            check("sb_event", obs, sb.pop_front());
    endtask

    always @(negedge clk100MHz) begin
        if (newKeyStrobe | releasePulse | frameError)
            check("strobe_release_excl", {31'd0, newKeyStrobe & releasePulse}, 32'd0);
        if (newKeyStrobe) begin
            n_strobes++;
            strobe_lat = cyc - last_fall_cyc;
            match(ev(K_MAKE, extended, keycode));
        end
        if (releasePulse) match(ev(K_REL, extended, keycode));
        if (frameError)   match(ev(K_ERR, extended, keycode));
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk100MHz);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            PS2Data = f[i];
            wait_cyc(HALF);
            PS2Clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bits(mk_frame(b, bad_par), 0, 10);
        wait_cyc(2 * HALF);
    endtask

    initial begin
        logic [10:0] f;
        int s0;
        rst_n = 1'b0;
        wait_cyc(3);
        check("rst_keycode", {24'd0, keycode}, 32'h00);
        check("rst_extended", {31'd0, extended}, 32'd0);
        check("rst_strobe", {31'd0, newKeyStrobe}, 32'd0);
        check("rst_release", {31'd0, releasePulse}, 32'd0);
        check("rst_frame_err", {31'd0, frameError}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Plain make; strobe lands 2 sync + 8 filter + edge + 2 = 12 cycles after raw fall.
        sb.push_back(ev(K_MAKE, 1'b0, 8'h1B));
        send_byte(8'h1B, 1'b0);
        check("s_keycode", {24'd0, keycode}, 32'h1B);
        check("s_extended", {31'd0, extended}, 32'd0);
        check("s_strobe_latency", strobe_lat, 32'd12);

        sb.push_back(ev(K_MAKE, 1'b1, 8'h75));
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("up_keycode", {24'd0, keycode}, 32'h75);
        check("up_extended", {31'd0, extended}, 32'd1);
        sb.push_back(ev(K_REL, 1'b0, 8'h00));
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("up_rel_keycode", {24'd0, keycode}, 32'h00);
        check("up_rel_extended", {31'd0, extended}, 32'd0);

        sb.push_back(ev(K_ERR, 1'b0, 8'h00));
        send_byte(8'h76, 1'b1);
        check("par_keycode", {24'd0, keycode}, 32'h00);
        sb.push_back(ev(K_MAKE, 1'b0, 8'h4D));
        send_byte(8'h4D, 1'b0);
        check("after_err_keycode", {24'd0, keycode}, 32'h4D);

        sb.push_back(ev(K_MAKE, 1'b0, 8'h6B));
        send_byte(8'h6B, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h74, 1'b0);
        check("nonheld_rel_keycode", {24'd0, keycode}, 32'h6B);
        check("nonheld_rel_drained", sb.size(), 32'd0);

        sb.push_back(ev(K_ERR, 1'b0, 8'h6B));
        send_bits(mk_frame(8'h2D, 1'b0), 0, 4);
        wait_cyc(TO + 200);
        check("timeout_bitcnt", {28'd0, dut.bit_cnt}, 32'd0);
        check("timeout_drained", sb.size(), 32'd0);
        sb.push_back(ev(K_MAKE, 1'b0, 8'h2D));
        send_byte(8'h2D, 1'b0);
        check("after_to_keycode", {24'd0, keycode}, 32'h2D);

        s0 = n_strobes;
        sb.push_back(ev(K_MAKE, 1'b0, 8'h1B));
`ifndef KEY_REPEAT_FILTER_EN
        sb.push_back(ev(K_MAKE, 1'b0, 8'h1B));
        sb.push_back(ev(K_MAKE, 1'b0, 8'h1B));
`endif
        for (int i = 0; i < 3; i++) send_byte(8'h1B, 1'b0);
`ifdef KEY_REPEAT_FILTER_EN
        check("repeat_strobes", n_strobes - s0, 32'd1);
`else
        check("repeat_strobes", n_strobes - s0, 32'd3);
`endif
        check("repeat_keycode", {24'd0, keycode}, 32'h1B);

        // Reset mid-frame: tail leaves a 6-bit partial frame that only the timeout discards.
        f = mk_frame(8'h33, 1'b0);
        send_bits(f, 0, 4);
        rst_n = 1'b0;
        #2;
        check("midrst_keycode", {24'd0, keycode}, 32'h00);
        check("midrst_extended", {31'd0, extended}, 32'd0);
        wait_cyc(1);
        rst_n = 1'b1;
        send_bits(f, 5, 10);
        wait_cyc(2 * HALF);
        check("midrst_tail_quiet", sb.size(), 32'd0);
        sb.push_back(ev(K_ERR, 1'b0, 8'h00));
        wait_cyc(TO + 200);
        check("midrst_drained", sb.size(), 32'd0);
        sb.push_back(ev(K_MAKE, 1'b0, 8'h1B));
        send_byte(8'h1B, 1'b0);
        check("midrst_next_keycode", {24'd0, keycode}, 32'h1B);

        PS2Clk = 1'b0;
        wait_cyc(3);
        PS2Clk = 1'b1;
        wait_cyc(30);
        check("glitch_bitcnt", {28'd0, dut.bit_cnt}, 32'd0);
        sb.push_back(ev(K_MAKE, 1'b0, 8'h5A));
        send_byte(8'h5A, 1'b0);
        check("glitch_next_keycode", {24'd0, keycode}, 32'h5A);

        wait_cyc(20);
        check("sb_final_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
